dht11_read_scheduler: RTL and testbench

Sequences a one-shot DHT11 reader engine and shares it between two on-chip requesters (display and game logic) plus an internal auto-poll timer. Enforces the sensor's minimum inter-read interval, applies a per-transaction timeout and bounded retries, and caches the last valid humidity/temperature pair. Sits between the tamagotchi logic and the single-wire DHT11 reader; it is the only block allowed to start a sensor transaction.

---
 rtl/dht11_sched_pkg.sv | 18 +
 rtl/dht11_read_scheduler_counter.sv | 34 +++
 rtl/dht11_read_scheduler.sv | 174 +++++++++++++++++
 tb/tb_dht11_read_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_sched_pkg.sv
// Shared types and constants for the DHT11 read scheduler.
// Holds the FSM state encoding, requester indices and counter widths.
package dht11_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DONE,
    EVAL,
    RESPOND
  } state_t;

  localparam int REQ_DISPLAY  = 0;
  localparam int REQ_GAME     = 1;
  localparam int NUM_REQ      = 2;
  localparam int FAIL_COUNT_W = 8;

endpackage

// File: rtl/dht11_read_scheduler_counter.sv
// sched_counter: up-counter with clear and enable; saturates at LIMIT
// or wraps to 0 after LIMIT. Ports: clk, rst, clr, en -> term (count==LIMIT).
module sched_counter #(
  parameter int LIMIT = 1,
  parameter bit WRAP  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [W-1:0] LIM = W'(LIMIT);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      if (count != LIM) begin
        count <= count + ONE;
      end else if (WRAP) begin
        count <= '0;
      end
    end
  end

  assign term = (count == LIM);

endmodule

// File: rtl/dht11_read_scheduler.sv
// Arbitrates the single DHT11 reader between two requesters and an
// auto-poll timer, with hold-off, timeout, retries and a result cache.
// Ports: clk/rst; req/auto_en in; gnt/resp_ok out; rd_* reader link;
// humidity/temperature/data_valid cache; busy; fail_count.
module dht11_read_scheduler
  import dht11_sched_pkg::*;
#(
  parameter int MIN_INTERVAL = 25000000,
  parameter int TIMEOUT      = 6250000,
  parameter int MAX_RETRY    = 2,
  parameter int AUTO_PERIOD  = 125000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic                    auto_en,
  output logic [NUM_REQ-1:0]      gnt,
  output logic                    resp_ok,
  output logic                    rd_start,
  input  logic                    rd_done,
  input  logic                    rd_valid,
  input  logic [15:0]             rd_humidity,
  input  logic [15:0]             rd_temperature,
  output logic [15:0]             humidity,
  output logic [15:0]             temperature,
  output logic                    data_valid,
  output logic                    busy,
  output logic [FAIL_COUNT_W-1:0] fail_count
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  localparam logic [RW-1:0] RONE = RW'(1);
  localparam logic [FAIL_COUNT_W-1:0] FONE = FAIL_COUNT_W'(1);

  state_t             state;
  logic [NUM_REQ-1:0] served;
  logic [RW-1:0]      retry;
  logic               retry_pend;
  logic               auto_pend;
  logic               done_seen;
  logic               tmp_valid;
  logic [15:0]        tmp_h;
  logic [15:0]        tmp_t;

  logic guard_ok;
  logic tmo_hit;
  logic auto_term;
  logic eval_entry;
  logic first_start;

  // Guard restarts when a transaction finishes (entering EVAL),
  // and from zero on reset, giving the power-up hold-off.
  assign eval_entry  = (state == WAIT_DONE) && (rd_done || tmo_hit);
  assign first_start = (state == START) && !retry_pend;

  sched_counter #(.LIMIT(MIN_INTERVAL), .WRAP(1'b0)) u_guard (
    .clk  (clk),
    .rst  (rst),
    .clr  (eval_entry),
    .en   (1'b1),
    .term (guard_ok)
  );

  sched_counter #(.LIMIT(TIMEOUT - 1), .WRAP(1'b0)) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == START),
    .en   (state == WAIT_DONE),
    .term (tmo_hit)
  );

  sched_counter #(.LIMIT(AUTO_PERIOD - 1), .WRAP(1'b1)) u_auto (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .en   (auto_en),
    .term (auto_term)
  );

  // A wrap in the same cycle as the snapshot re-arms the poll.
  always_ff @(posedge clk) begin
    if (rst || !auto_en) begin
      auto_pend <= 1'b0;
    end else if (auto_term) begin
      auto_pend <= 1'b1;
    end else if (first_start) begin
      auto_pend <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= '0;
      resp_ok     <= 1'b0;
      rd_start    <= 1'b0;
      humidity    <= '0;
      temperature <= '0;
      data_valid  <= 1'b0;
      fail_count  <= '0;
      served      <= '0;
      retry       <= '0;
      retry_pend  <= 1'b0;
      done_seen   <= 1'b0;
      tmp_valid   <= 1'b0;
      tmp_h       <= '0;
      tmp_t       <= '0;
    end else begin
      rd_start <= 1'b0;
      gnt      <= '0;
      resp_ok  <= 1'b0;
      unique case (state)
        IDLE: begin
          if ((|req || auto_pend || retry_pend) && guard_ok) begin
            state    <= START;
            rd_start <= 1'b1;
          end
        end
        START: begin
          if (!retry_pend) begin
            served <= req;
          end
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (rd_done) begin
            done_seen <= 1'b1;
            tmp_valid <= rd_valid;
            tmp_h     <= rd_humidity;
            tmp_t     <= rd_temperature;
            state     <= EVAL;
          end else if (tmo_hit) begin
            done_seen <= 1'b0;
            state     <= EVAL;
          end
        end
        EVAL: begin
          // gnt/resp_ok are issued here so they are seen during RESPOND.
          if (done_seen && tmp_valid) begin
            humidity    <= tmp_h;
            temperature <= tmp_t;
            data_valid  <= 1'b1;
            retry       <= '0;
            gnt         <= served;
            resp_ok     <= 1'b1;
            state       <= RESPOND;
          end else if (retry < RMAX) begin
            retry      <= retry + RONE;
            retry_pend <= 1'b1;
            state      <= IDLE;
          end else begin
            if (fail_count != '1) begin
              fail_count <= fail_count + FONE;
            end
            retry   <= '0;
            gnt     <= served;
            resp_ok <= 1'b0;
            state   <= RESPOND;
          end
        end
        RESPOND: begin
          served     <= '0;
          retry_pend <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Directed bench for dht11_read_scheduler with short intervals.
// Acts as requesters and as the DHT11 reader engine.
module tb_dht11_read_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic        auto_en;
  logic [1:0]  gnt;
  logic        resp_ok;
  logic        rd_start;
  logic        rd_done;
  logic        rd_valid;
  logic [15:0] rd_humidity;
  logic [15:0] rd_temperature;
  logic [15:0] humidity;
  logic [15:0] temperature;
  logic        data_valid;
  logic        busy;
  logic [7:0]  fail_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int nstart = 0;
  int ngnt = 0;
  int eval_cyc = 0;

  dht11_read_scheduler #(
    .MIN_INTERVAL (100),
    .TIMEOUT      (50),
    .MAX_RETRY    (2),
    .AUTO_PERIOD  (1000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .auto_en        (auto_en),
    .gnt            (gnt),
    .resp_ok        (resp_ok),
    .rd_start       (rd_start),
    .rd_done        (rd_done),
    .rd_valid       (rd_valid),
    .rd_humidity    (rd_humidity),
    .rd_temperature (rd_temperature),
    .humidity       (humidity),
    .temperature    (temperature),
    .data_valid     (data_valid),
    .busy           (busy),
    .fail_count     (fail_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_start) nstart <= nstart + 1;
    if (|gnt) ngnt <= ngnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ge(input string tag, input int obs, input int lo);
    vectors++;
    assert (obs >= lo) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected >= %0d", tag, obs, lo);
    end
  endtask

  task automatic wait_start(input string tag, input int budget,
                            output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (rd_start) begin
        at = cyc;
        break;
      end
    end
    vectors++;
    assert (at >= 0) else begin
      miscompares++;
      $error("FAIL %s: observed no rd_start expected one within %0d",
             tag, budget);
    end
  endtask

  task automatic wait_gnt(input string tag, input int budget,
                          output int at, output logic [1:0] g,
                          output logic ok);
    at = -1;
    g = 2'b00;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (|gnt) begin
        at = cyc;
        g = gnt;
        ok = resp_ok;
        break;
      end
    end
    vectors++;
    assert (at >= 0) else begin
      miscompares++;
      $error("FAIL %s: observed no gnt expected one within %0d",
             tag, budget);
    end
  endtask

  // Caller is in WAIT_DONE; returns with the DUT in EVAL.
  task automatic reply(input logic v, input logic [15:0] h,
                       input logic [15:0] t);
    rd_done = 1'b1;
    rd_valid = v;
    rd_humidity = h;
    rd_temperature = t;
    tick();
    eval_cyc = cyc;
    rd_done = 1'b0;
    rd_valid = 1'b0;
  endtask

  initial begin
    int s, s1, s2, s3, r0, n0, g0, at;
    logic [1:0] g;
    logic ok;

    rst = 1'b1;
    req = 2'b00;
    auto_en = 1'b0;
    rd_done = 1'b0;
    rd_valid = 1'b0;
    rd_humidity = '0;
    rd_temperature = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_gnt", gnt, 0);
    check("rst_start", rd_start, 0);
    check("rst_hum", humidity, 0);
    check("rst_dv", data_valid, 0);
    check("rst_fail", fail_count, 0);

    // Power-up hold-off, then a good read.
    req = 2'b01;
    rst = 1'b0;
    r0 = cyc;
    wait_start("holdoff_start", 300, s);
    check("holdoff_cycles", s - r0, 101);
    check("busy_start", busy, 1);
    tick();
    reply(1'b1, 16'h3200, 16'h1900);
    tick();
    check("s1_gnt", gnt, 2'b01);
    check("s1_ok", resp_ok, 1);
    check("s1_hum", humidity, 16'h3200);
    check("s1_temp", temperature, 16'h1900);
    check("s1_dv", data_valid, 1);
    req = 2'b00;
    tick();
    check("s1_gnt_pulse", gnt, 2'b00);

    // Stray rd_done while idle must not touch the cache.
    rd_done = 1'b1;
    rd_valid = 1'b1;
    rd_humidity = 16'hbeef;
    tick();
    rd_done = 1'b0;
    rd_valid = 1'b0;
    repeat (2) tick();
    check("stray_hum", humidity, 16'h3200);
    check("stray_busy", busy, 0);

    // Second requester rises in the START cycle: served together.
    req = 2'b01;
    n0 = nstart;
    wait_start("coal_a_start", 300, s);
    check_ge("coal_a_gap", s - eval_cyc, 100);
    req = 2'b11;
    tick();
    reply(1'b1, 16'h3000, 16'h1800);
    tick();
    check("coal_a_gnt", gnt, 2'b11);
    req = 2'b00;
    tick();
    check("coal_a_starts", nstart - n0, 1);

    // Second requester rises one cycle late: two transactions.
    req = 2'b01;
    wait_start("coal_b_start1", 300, s);
    tick();
    req = 2'b11;
    reply(1'b1, 16'h2a00, 16'h1a00);
    tick();
    check("coal_b_gnt1", gnt, 2'b01);
    req = 2'b10;
    wait_start("coal_b_start2", 300, s);
    check_ge("coal_b_gap", s - eval_cyc, 100);
    tick();
    reply(1'b1, 16'h2b00, 16'h1b00);
    tick();
    check("coal_b_gnt2", gnt, 2'b10);
    req = 2'b00;

    // Silent reader: three timed-out attempts, then a failed grant.
    req = 2'b01;
    n0 = nstart;
    wait_start("tmo_start1", 300, s1);
    wait_start("tmo_start2", 400, s2);
    check_ge("tmo_gap1", s2 - s1, 151);
    wait_start("tmo_start3", 400, s3);
    check_ge("tmo_gap2", s3 - s2, 151);
    wait_gnt("tmo_gnt_wait", 200, at, g, ok);
    check("tmo_gnt", g, 2'b01);
    check("tmo_ok", ok, 0);
    check("tmo_latency", at - s3, 52);
    check("tmo_fail", fail_count, 1);
    check("tmo_hum", humidity, 16'h2b00);
    req = 2'b00;
    tick();
    check("tmo_starts", nstart - n0, 3);

    // Bad checksum, then a good retry.
    req = 2'b01;
    n0 = nstart;
    wait_start("bad_start1", 300, s);
    tick();
    reply(1'b0, 16'hdead, 16'hdead);
    wait_start("bad_start2", 300, s);
    check_ge("bad_gap", s - eval_cyc, 100);
    tick();
    reply(1'b1, 16'h2800, 16'h1400);
    tick();
    check("bad_gnt", gnt, 2'b01);
    check("bad_ok", resp_ok, 1);
    check("bad_hum", humidity, 16'h2800);
    check("bad_fail", fail_count, 1);
    req = 2'b00;
    tick();
    check("bad_starts", nstart - n0, 2);

    // Auto-poll with no requesters.
    n0 = nstart;
    g0 = ngnt;
    auto_en = 1'b1;
    wait_start("auto_start1", 1200, s1);
    tick();
    reply(1'b1, 16'h1111, 16'h2222);
    tick();
    check("auto_hum", humidity, 16'h1111);
    wait_start("auto_start2", 1200, s2);
    check("auto_period", s2 - s1, 1000);
    tick();
    reply(1'b1, 16'h1212, 16'h2323);
    tick();
    check("auto_temp", temperature, 16'h2323);
    auto_en = 1'b0;
    repeat (2500) tick();
    check("auto_starts", nstart - n0, 2);
    check("auto_gnts", ngnt - g0, 0);

    // Reset while waiting on the reader.
    req = 2'b01;
    wait_start("rst_mid_start", 300, s);
    repeat (6) tick();
    check("rst_mid_busy", busy, 1);
    g0 = ngnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r0 = cyc;
    check("rst_mid_busy0", busy, 0);
    check("rst_mid_gnt", gnt, 0);
    check("rst_mid_hum", humidity, 0);
    check("rst_mid_temp", temperature, 0);
    check("rst_mid_dv", data_valid, 0);
    check("rst_mid_fail", fail_count, 0);
    wait_start("rst_mid_restart", 300, s);
    check("rst_mid_holdoff", s - r0, 101);
    check("rst_mid_nognt", ngnt - g0, 0);
    tick();
    reply(1'b1, 16'h0a0a, 16'h0b0b);
    tick();
    check("rst_mid_gnt2", gnt, 2'b01);
    check("rst_mid_dv2", data_valid, 1);
    req = 2'b00;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
